// File: rtl/encode_lanes.sv
// Multi-lane 8B/10B encoder (IEEE 802.3 Clause 36 code tables) with a
// single-entry valid/ready output register and a chained running disparity.
module encode_lanes #(
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*LANES-1:0]    data_in,
    input  logic [LANES-1:0]      k_in,
    input  logic                  rd_load,
    input  logic                  rd_load_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*LANES-1:0]   code_out,
    output logic [LANES-1:0]      k_err,
    output logic                  rd_out
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [10*LANES-1:0]   code_q, code_d;
    logic [LANES-1:0]      kerr_q, kerr_d;
    logic                  rd_q, rd_d;
    logic                  xfer_s;
    logic                  rd_chain_s;
    logic [11:0]           lane_s;
    logic [10*LANES-1:0]   word_code_s;
    logic [LANES-1:0]      word_kerr_s;
    logic                  word_rd_s;

    // 5b/6b abcdei codes in the RD- column; RD+ is derived by complementing.
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        case (x)
            5'd0:  enc6_neg = 6'b100111;
            5'd1:  enc6_neg = 6'b011101;
            5'd2:  enc6_neg = 6'b101101;
            5'd3:  enc6_neg = 6'b110001;
            5'd4:  enc6_neg = 6'b110101;
            5'd5:  enc6_neg = 6'b101001;
            5'd6:  enc6_neg = 6'b011001;
            5'd7:  enc6_neg = 6'b111000;
            5'd8:  enc6_neg = 6'b111001;
            5'd9:  enc6_neg = 6'b100101;
            5'd10: enc6_neg = 6'b010101;
            5'd11: enc6_neg = 6'b110100;
            5'd12: enc6_neg = 6'b001101;
            5'd13: enc6_neg = 6'b101100;
            5'd14: enc6_neg = 6'b011100;
            5'd15: enc6_neg = 6'b010111;
            5'd16: enc6_neg = 6'b011011;
            5'd17: enc6_neg = 6'b100011;
            5'd18: enc6_neg = 6'b010011;
            5'd19: enc6_neg = 6'b110010;
            5'd20: enc6_neg = 6'b001011;
            5'd21: enc6_neg = 6'b101010;
            5'd22: enc6_neg = 6'b011010;
            5'd23: enc6_neg = 6'b111010;
            5'd24: enc6_neg = 6'b110011;
            5'd25: enc6_neg = 6'b100110;
            5'd26: enc6_neg = 6'b010110;
            5'd27: enc6_neg = 6'b110110;
            5'd28: enc6_neg = 6'b001110;
            5'd29: enc6_neg = 6'b101110;
            5'd30: enc6_neg = 6'b011110;
            default: enc6_neg = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] enc4_d_neg(input logic [2:0] y, input logic a7);
        case (y)
            3'd0:    enc4_d_neg = 4'b1011;
            3'd1:    enc4_d_neg = 4'b1001;
            3'd2:    enc4_d_neg = 4'b0101;
            3'd3:    enc4_d_neg = 4'b1100;
            3'd4:    enc4_d_neg = 4'b1101;
            3'd5:    enc4_d_neg = 4'b1010;
            3'd6:    enc4_d_neg = 4'b0110;
            default: enc4_d_neg = a7 ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    // K fghj codes are complemented at RD+ even when balanced, preserving the comma.
    function automatic logic [3:0] enc4_k_neg(input logic [2:0] y);
        case (y)
            3'd0:    enc4_k_neg = 4'b1011;
            3'd1:    enc4_k_neg = 4'b0110;
            3'd2:    enc4_k_neg = 4'b1010;
            3'd3:    enc4_k_neg = 4'b1100;
            3'd4:    enc4_k_neg = 4'b1101;
            3'd5:    enc4_k_neg = 4'b0101;
            3'd6:    enc4_k_neg = 4'b1001;
            default: enc4_k_neg = 4'b0111;
        endcase
    endfunction

    function automatic logic rd6_after(input logic [5:0] c, input logic rd);
        if (c == 6'b000111)                  rd6_after = 1'b1;
        else if (c == 6'b111000)             rd6_after = 1'b0;
        else if ($countones(c) > 32'd3)      rd6_after = 1'b1;
        else if ($countones(c) < 32'd3)      rd6_after = 1'b0;
        else                                 rd6_after = rd;
    endfunction

    function automatic logic rd4_after(input logic [3:0] c, input logic rd);
        if (c == 4'b0011)                    rd4_after = 1'b1;
        else if (c == 4'b1100)               rd4_after = 1'b0;
        else if ($countones(c) > 32'd2)      rd4_after = 1'b1;
        else if ($countones(c) < 32'd2)      rd4_after = 1'b0;
        else                                 rd4_after = rd;
    endfunction

    // Returns {k_err, rd_after, abcdei, fghj} for one byte lane.
    function automatic logic [11:0] enc_lane(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       k28, kv, rd6, a7, flip6, flip4;
        logic [5:0] base6, s6;
        logic [3:0] base4, s4;
        x     = b[4:0];
        y     = b[7:5];
        k28   = (x == 5'd28);
        kv    = k && (k28 || ((y == 3'd7) &&
                 ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
        base6 = (kv && k28) ? 6'b001111 : enc6_neg(x);
        flip6 = rd && (($countones(base6) != 32'd3) || (!kv && (x == 5'd7)));
        s6    = flip6 ? ~base6 : base6;
        rd6   = rd6_after(s6, rd);
        a7    = (y == 3'd7) &&
                ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        base4 = kv ? enc4_k_neg(y) : enc4_d_neg(y, a7);
        flip4 = rd6 && (kv || ($countones(base4) != 32'd2) || (y == 3'd3));
        s4    = flip4 ? ~base4 : base4;
        enc_lane = {k && !kv, rd4_after(s4, rd6), s6, s4};
    endfunction

    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign out_valid = (state_q == ST_FULL);
    assign code_out  = code_q;
    assign k_err     = kerr_q;
    assign rd_out    = rd_q;
    assign xfer_s    = in_valid && in_ready;

    // Lane chain: each lane starts from the disparity left by the lane below it.
    always_comb begin
        word_code_s = '0;
        word_kerr_s = '0;
        lane_s      = 12'd0;
        rd_chain_s  = rd_load ? rd_load_val : rd_q;
        for (int i = 0; i < LANES; i++) begin
            lane_s                   = enc_lane(data_in[8*i +: 8], k_in[i], rd_chain_s);
            word_code_s[10*i +: 10]  = lane_s[9:0];
            word_kerr_s[i]           = lane_s[11];
            rd_chain_s               = lane_s[10];
        end
        word_rd_s = rd_chain_s;
    end

    // Next state of the output register and running disparity.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        kerr_d  = kerr_q;
        rd_d    = rd_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_s) state_d = ST_FULL;
                else        state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_ready && !in_valid) state_d = ST_EMPTY;
                else                        state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (xfer_s) begin
            code_d = word_code_s;
            kerr_d = word_kerr_s;
            rd_d   = word_rd_s;
        end else if (rd_load) begin
            rd_d   = rd_load_val;
        end else begin
            rd_d   = rd_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            code_q  <= '0;
            kerr_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_encode_lanes.sv
// Bench for encode_lanes: a 1-lane and a 2-lane instance, directed vectors,
// backpressure/reset sequences and a randomized run against a table-based model.
module tb_encode_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic       iv1, ir1, k1, rdl1, rdv1, ov1, or1, kerr1, rdo1;
    logic [7:0] d1;
    logic [9:0] c1;

    logic        iv2, ir2, rdl2, rdv2, ov2, or2, rdo2;
    logic [15:0] d2;
    logic [1:0]  k2, kerr2;
    logic [19:0] c2;

    encode_lanes #(.LANES(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .data_in(d1),
        .k_in(k1), .rd_load(rdl1), .rd_load_val(rdv1), .out_valid(ov1),
        .out_ready(or1), .code_out(c1), .k_err(kerr1), .rd_out(rdo1));

    encode_lanes #(.LANES(2)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .data_in(d2),
        .k_in(k2), .rd_load(rdl2), .rd_load_val(rdv2), .out_valid(ov2),
        .out_ready(or2), .code_out(c2), .k_err(kerr2), .rd_out(rdo2));

    int n_checks = 0;
    int n_errors = 0;

    // Standard code tables, both disparity columns written out.
    logic [5:0] t6n [32];
    logic [5:0] t6p [32];
    logic [3:0] t4n [9];
    logic [3:0] t4p [9];
    logic [9:0] k28n [8];
    logic [9:0] k28p [8];
    logic [7:0] klist [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {k_err, rd_after, code10}; a code group with five ones keeps RD, any other flips it.
    function automatic logic [11:0] ref_lane(input logic [7:0] b, input logic k, input logic rd);
        int x, y, idx;
        logic kv, rd6;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] code;
        x  = int'(b[4:0]);
        y  = int'(b[7:5]);
        kv = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (kv && x == 28) begin
            code = rd ? k28p[y] : k28n[y];
        end else if (kv) begin
            code = rd ? {t6p[x], 4'b0111} : {t6n[x], 4'b1000};
        end else begin
            s6  = rd ? t6p[x] : t6n[x];
            rd6 = ($countones(s6) == 3) ? rd : ~rd;
            idx = y;
            if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                           ( rd6 && (x == 11 || x == 13 || x == 14))))
                idx = 8;
            s4   = rd6 ? t4p[idx] : t4n[idx];
            code = {s6, s4};
        end
        ref_lane = {k && !kv, ($countones(code) == 5) ? rd : ~rd, code};
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       k, rdl, rdv, iv, ev;
        logic [9:0] ec;
        logic       ek, er;
    } vec_t;
    vec_t vt [15];

    logic        mfull, mrd, r, xfer, exp_ir;
    logic [19:0] mcode;
    logic [1:0]  mkerr;
    logic [11:0] res;

    initial begin
        t6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        t6p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
        t4n  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110, 4'b0111};
        t4p  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001, 4'b1000};
        k28n = '{10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
                 10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000};
        k28p = '{10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
                 10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111};
        klist = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                  8'hF7, 8'hFB, 8'hFD, 8'hFE};

        //            d      k     rdl   rdv   iv    ev    code            kerr  rd
        vt[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1001110100, 1'b0, 1'b0};
        vt[1]  = '{8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b0011111010, 1'b0, 1'b1};
        vt[2]  = '{8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1100000101, 1'b0, 1'b0};
        vt[3]  = '{8'hF1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1000110111, 1'b0, 1'b1};
        vt[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b0000000000, 1'b0, 1'b0};
        vt[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b0011110100, 1'b0, 1'b0};
        vt[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1001110100, 1'b1, 1'b0};
        vt[7]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'b0110001011, 1'b0, 1'b1};
        vt[8]  = '{8'hEB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1101001000, 1'b0, 1'b0};
        vt[9]  = '{8'hF7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1110101000, 1'b0, 1'b0};
        vt[10] = '{8'h67, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1110001100, 1'b0, 1'b0};
        vt[11] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1010110001, 1'b0, 1'b0};
        vt[12] = '{8'hFC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'b1100000111, 1'b0, 1'b1};
        vt[13] = '{8'hB5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1010101010, 1'b1, 1'b1};
        vt[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000000000, 1'b0, 1'b1};

        reset = 1'b0;
        {iv1, k1, rdl1, rdv1, or1, d1} = '0;
        {iv2, k2, rdl2, rdv2, or2, d2} = '0;
        tick();
        tick();
        chk("rst_ov1", ov1, 1'b0);
        chk("rst_c1", c1, 10'd0);
        chk("rst_rd1", rdo1, 1'b0);
        chk("rst_ir1", ir1, 1'b1);
        chk("rst_ov2", ov2, 1'b0);
        chk("rst_c2", c2, 20'd0);
        chk("rst_kerr2", kerr2, 2'd0);
        reset = 1'b1;

        // Directed single-lane vectors, one word per cycle, sink always ready.
        or1 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            d1 = vt[i].d; k1 = vt[i].k; rdl1 = vt[i].rdl; rdv1 = vt[i].rdv; iv1 = vt[i].iv;
            tick();
            chk($sformatf("vec%0d_valid", i), ov1, vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_code", i), c1, vt[i].ec);
                chk($sformatf("vec%0d_kerr", i), kerr1, vt[i].ek);
            end
            chk($sformatf("vec%0d_rd", i), rdo1, vt[i].er);
        end

        // Reset while holding a word; first word afterwards must start at RD-.
        iv1 = 1'b1; d1 = 8'h00; k1 = 1'b0; rdl1 = 1'b0;
        tick();
        chk("pre_rst_code", c1, 10'b0110001011);
        iv1 = 1'b0; or1 = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_ov", ov1, 1'b0);
        chk("async_rst_rd", rdo1, 1'b0);
        chk("async_rst_code", c1, 10'd0);
        tick();
        reset = 1'b1;
        iv1 = 1'b1; or1 = 1'b1;
        tick();
        chk("post_rst_code", c1, 10'b1001110100);
        chk("post_rst_rd", rdo1, 1'b0);
        iv1 = 1'b0;

        // Two lanes: K28.5 then D0.0 chained, then backpressure hold.
        iv2 = 1'b1; d2 = {8'h00, 8'hBC}; k2 = 2'b01; or2 = 1'b0;
        #1;
        chk("bp_ir_empty", ir2, 1'b1);
        tick();
        chk("two_lane_code", c2, {10'b0110001011, 10'b0011111010});
        chk("two_lane_rd", rdo2, 1'b1);
        d2 = 16'h0000; k2 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ir_full", ir2, 1'b0);
            tick();
            chk("bp_hold_code", c2, {10'b0110001011, 10'b0011111010});
            chk("bp_hold_valid", ov2, 1'b1);
            chk("bp_hold_rd", rdo2, 1'b1);
        end
        or2 = 1'b1;
        #1;
        chk("bp_ir_release", ir2, 1'b1);
        tick();
        chk("bp_next_code", c2, {10'b0110001011, 10'b0110001011});
        chk("bp_next_rd", rdo2, 1'b1);
        iv2 = 1'b0;
        tick();
        chk("bp_drain_valid", ov2, 1'b0);

        // Randomized traffic on the two-lane instance from a fresh reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mfull = 1'b0; mrd = 1'b0; mcode = '0; mkerr = '0;
        for (int c = 0; c < 600; c++) begin
            iv2  = ($urandom_range(0, 3) != 0);
            or2  = ($urandom_range(0, 3) != 0);
            rdl2 = ($urandom_range(0, 15) == 0);
            rdv2 = 1'($urandom_range(0, 1));
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 3) == 0) begin
                    k2[l] = 1'b1;
                    if ($urandom_range(0, 3) != 0) d2[8*l +: 8] = klist[$urandom_range(0, 11)];
                    else                           d2[8*l +: 8] = 8'($urandom_range(0, 255));
                end else begin
                    k2[l] = 1'b0;
                    d2[8*l +: 8] = 8'($urandom_range(0, 255));
                end
            end
            #1;
            exp_ir = !mfull || or2;
            chk("rnd_in_ready", ir2, exp_ir);
            xfer = iv2 && exp_ir;
            if (xfer) begin
                r = rdl2 ? rdv2 : mrd;
                for (int l = 0; l < 2; l++) begin
                    res = ref_lane(d2[8*l +: 8], k2[l], r);
                    mcode[10*l +: 10] = res[9:0];
                    mkerr[l] = res[11];
                    r = res[10];
                end
                mrd = r;
                mfull = 1'b1;
            end else begin
                if (rdl2) mrd = rdv2;
                if (mfull && or2) mfull = 1'b0;
            end
            tick();
            chk("rnd_valid", ov2, mfull);
            chk("rnd_rd", rdo2, mrd);
            if (mfull) begin
                chk("rnd_code", c2, mcode);
                chk("rnd_kerr", kerr2, mkerr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
